// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address sequencer with boot hold, load-use stall and
// branch/jump redirect handling.
//
// Optional feature: define PC_SEQ_DELAY_SLOT_EN to give redirects a single
// delay slot. An accepted redirect then advances pc by 4, saves the target,
// and loads that target one cycle later instead of flushing IF/ID.
//
// Parameters:
//   RESET_PC     PC value loaded by reset.
//   BOOT_CYCLES  Cycles fetch is held after reset release (1..15).
//
// Ports:
//   clk            in   single clock, rising edge
//   rst_n          in   synchronous active-low reset
//   branch_taken   in   conditional-branch redirect request (from EX)
//   branch_target  in   branch destination, low two bits ignored
//   jump           in   unconditional jump redirect request (from ID)
//   jump_target    in   jump destination, low two bits ignored
//   stall          in   load-use hazard hold request
//   pc             out  registered fetch address
//   pc_src         out  source of the current pc: 0 seq, 1 branch, 2 jump, 3 hold
//   if_id_write    out  IF/ID pipeline register enable
//   if_id_flush    out  IF/ID pipeline register clear
//   busy           out  high while booting or sitting in the delay slot
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [1:0]  pc_src,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        busy
);

    localparam logic [1:0] SrcSeq    = 2'd0;
    localparam logic [1:0] SrcBranch = 2'd1;
    localparam logic [1:0] SrcJump   = 2'd2;
    localparam logic [1:0] SrcHold   = 2'd3;

    localparam logic [3:0] BootLast = 4'(BOOT_CYCLES - 1);

`ifdef PC_SEQ_DELAY_SLOT_EN
    typedef enum logic [1:0] {StBoot, StRun, StStall, StDelay} state_e;
`else
    typedef enum logic [1:0] {StBoot, StRun, StStall} state_e;
`endif

    state_e      state_q, state_d;
    logic [3:0]  boot_cnt_q, boot_cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  pc_src_q, pc_src_d;
    logic        if_id_write_q, if_id_write_d;
    logic        if_id_flush_q, if_id_flush_d;
    logic        busy_q, busy_d;

`ifdef PC_SEQ_DELAY_SLOT_EN
    logic [31:0] saved_target_q, saved_target_d;
    logic [1:0]  saved_src_q, saved_src_d;
`endif

    logic [31:0] pc_seq;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [1:0]  redirect_src;

    assign pc_seq = pc_q + 32'd4;

    // Branch beats stall; a jump is only honoured when no stall is pending.
    assign redirect        = branch_taken | (jump & ~stall);
    assign redirect_target = branch_taken ? {branch_target[31:2], 2'b00}
                                          : {jump_target[31:2], 2'b00};
    assign redirect_src    = branch_taken ? SrcBranch : SrcJump;

    always_comb begin
        state_d       = state_q;
        boot_cnt_d    = boot_cnt_q;
        pc_d          = pc_q;
        pc_src_d      = SrcHold;
        if_id_write_d = 1'b0;
        if_id_flush_d = 1'b0;
        busy_d        = 1'b0;
`ifdef PC_SEQ_DELAY_SLOT_EN
        saved_target_d = saved_target_q;
        saved_src_d    = saved_src_q;
`endif

        case (state_q)
            StBoot: begin
                // Redirects are ignored; pc stays put through the last boot edge.
                if (boot_cnt_q == BootLast) begin
                    state_d       = StRun;
                    if_id_write_d = 1'b1;
                end else begin
                    boot_cnt_d    = boot_cnt_q + 4'd1;
                    if_id_flush_d = 1'b1;
                    busy_d        = 1'b1;
                end
            end

            StRun, StStall: begin
                if (redirect) begin
`ifdef PC_SEQ_DELAY_SLOT_EN
                    pc_d           = pc_seq;
                    pc_src_d       = SrcSeq;
                    if_id_write_d  = 1'b1;
                    saved_target_d = redirect_target;
                    saved_src_d    = redirect_src;
                    busy_d         = 1'b1;
                    state_d        = StDelay;
`else
                    pc_d          = redirect_target;
                    pc_src_d      = redirect_src;
                    if_id_write_d = 1'b1;
                    if_id_flush_d = 1'b1;
                    state_d       = StRun;
`endif
                end else if (stall) begin
                    state_d = StStall;
                end else begin
                    pc_d          = pc_seq;
                    pc_src_d      = SrcSeq;
                    if_id_write_d = 1'b1;
                    state_d       = StRun;
                end
            end

`ifdef PC_SEQ_DELAY_SLOT_EN
            StDelay: begin
                // Stall freezes the slot; new redirects are dropped here.
                if (stall) begin
                    busy_d = 1'b1;
                end else begin
                    pc_d          = saved_target_q;
                    pc_src_d      = saved_src_q;
                    if_id_write_d = 1'b1;
                    state_d       = StRun;
                end
            end
`endif

            default: begin
                state_d    = StBoot;
                boot_cnt_d = 4'd0;
                busy_d     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StBoot;
            boot_cnt_q    <= 4'd0;
            pc_q          <= RESET_PC;
            pc_src_q      <= SrcHold;
            if_id_write_q <= 1'b0;
            if_id_flush_q <= 1'b1;
            busy_q        <= 1'b1;
`ifdef PC_SEQ_DELAY_SLOT_EN
            saved_target_q <= 32'h0;
            saved_src_q    <= SrcSeq;
`endif
        end else begin
            state_q       <= state_d;
            boot_cnt_q    <= boot_cnt_d;
            pc_q          <= pc_d;
            pc_src_q      <= pc_src_d;
            if_id_write_q <= if_id_write_d;
            if_id_flush_q <= if_id_flush_d;
            busy_q        <= busy_d;
`ifdef PC_SEQ_DELAY_SLOT_EN
            saved_target_q <= saved_target_d;
            saved_src_q    <= saved_src_d;
`endif
        end
    end

    assign pc          = pc_q;
    assign pc_src      = pc_src_q;
    assign if_id_write = if_id_write_q;
    assign if_id_flush = if_id_flush_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer. Each check compares the packed tuple
// {pc, pc_src, if_id_write, if_id_flush, busy} against a hand-computed value.
// Delay-slot scenarios are built when PC_SEQ_DELAY_SLOT_EN is defined.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        stall;
    logic [31:0] pc;
    logic [1:0]  pc_src;
    logic        if_id_write;
    logic        if_id_flush;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    logic [36:0] exp_v;

    pc_sequencer #(
        .RESET_PC    (RST_PC),
        .BOOT_CYCLES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .stall         (stall),
        .pc            (pc),
        .pc_src        (pc_src),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [36:0] obs();
        return {pc, pc_src, if_id_write, if_id_flush, busy};
    endfunction

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steer pc to addr via a jump; no checks.
    task automatic goto(input logic [31:0] addr);
        jump = 1'b1;
        jump_target = addr;
        step();
        jump = 1'b0;
`ifdef PC_SEQ_DELAY_SLOT_EN
        step();
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        exp_v = {RST_PC, 2'd3, 1'b0, 1'b1, 1'b1};
        vectors++;
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL reset_load got=%h want=%h", obs(), exp_v);
        end
        rst_n = 1'b1;
        step();
        exp_v = {RST_PC, 2'd3, 1'b0, 1'b1, 1'b1};
        vectors++;
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL boot_1 got=%h want=%h", obs(), exp_v);
        end
        step();
        exp_v = {RST_PC, 2'd3, 1'b1, 1'b0, 1'b0};
        vectors++;
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL boot_exit got=%h want=%h", obs(), exp_v);
        end
        step();
        exp_v = {RST_PC + 32'd4, 2'd0, 1'b1, 1'b0, 1'b0};
        vectors++;
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL run_seq1 got=%h want=%h", obs(), exp_v);
        end
        step();
        exp_v = {RST_PC + 32'd8, 2'd0, 1'b1, 1'b0, 1'b0};
        vectors++;
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL run_seq2 got=%h want=%h", obs(), exp_v);
        end
    endtask

    task automatic test_wrap();
        goto(32'hFFFF_FFFF);
        vectors++;
        if (pc !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL target_mask got=%h want=%h", pc, 32'hFFFF_FFFC);
        end
        step();
        exp_v = {32'h0000_0000, 2'd0, 1'b1, 1'b0, 1'b0};
        vectors++;
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL wrap got=%h want=%h", obs(), exp_v);
        end
    endtask

    task automatic test_stall();
        goto(32'h0000_0100);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_v = {32'h0000_0100, 2'd3, 1'b0, 1'b0, 1'b0};
            vectors++;
            if (obs() !== exp_v) begin
                miscompares++;
                $display("FAIL stall_hold%0d got=%h want=%h", i, obs(), exp_v);
            end
        end
        stall = 1'b0;
        step();
        exp_v = {32'h0000_0104, 2'd0, 1'b1, 1'b0, 1'b0};
        vectors++;
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL stall_release got=%h want=%h", obs(), exp_v);
        end
    endtask

    task automatic test_priority();
        goto(32'h0000_0500);
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0203;
        stall         = 1'b1;
        jump          = 1'b1;
        jump_target   = 32'h0000_0700;
        step();
        branch_taken = 1'b0;
        stall        = 1'b0;
        jump         = 1'b0;
`ifdef PC_SEQ_DELAY_SLOT_EN
        exp_v = {32'h0000_0504, 2'd0, 1'b1, 1'b0, 1'b1};
        vectors++;
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL prio_slot got=%h want=%h", obs(), exp_v);
        end
        step();
        exp_v = {32'h0000_0200, 2'd1, 1'b1, 1'b0, 1'b0};
`else
        exp_v = {32'h0000_0200, 2'd1, 1'b1, 1'b1, 1'b0};
`endif
        vectors++;
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL prio_branch got=%h want=%h", obs(), exp_v);
        end
        step();
        exp_v = {32'h0000_0204, 2'd0, 1'b1, 1'b0, 1'b0};
        vectors++;
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL prio_after got=%h want=%h", obs(), exp_v);
        end
    endtask

    task automatic test_jump_during_stall();
        stall       = 1'b1;
        jump        = 1'b1;
        jump_target = 32'h0000_0604;
        step();
        exp_v = {32'h0000_0204, 2'd3, 1'b0, 1'b0, 1'b0};
        vectors++;
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL jump_held got=%h want=%h", obs(), exp_v);
        end
        stall = 1'b0;
        step();
        jump = 1'b0;
`ifdef PC_SEQ_DELAY_SLOT_EN
        step();
        exp_v = {32'h0000_0604, 2'd2, 1'b1, 1'b0, 1'b0};
`else
        exp_v = {32'h0000_0604, 2'd2, 1'b1, 1'b1, 1'b0};
`endif
        vectors++;
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL jump_released got=%h want=%h", obs(), exp_v);
        end
    endtask

    // Reset mid-stall, with redirects presented during boot.
    task automatic test_reset_mid_stall();
        stall = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        exp_v = {RST_PC, 2'd3, 1'b0, 1'b1, 1'b1};
        vectors++;
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL rst_mid_stall got=%h want=%h", obs(), exp_v);
        end
        rst_n         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0040;
        jump          = 1'b1;
        jump_target   = 32'h0000_0080;
        step();
        step();
        exp_v = {RST_PC, 2'd3, 1'b1, 1'b0, 1'b0};
        vectors++;
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL boot_ignores_redirect got=%h want=%h", obs(), exp_v);
        end
        branch_taken = 1'b0;
        jump         = 1'b0;
        step();
        exp_v = {RST_PC + 32'd4, 2'd0, 1'b1, 1'b0, 1'b0};
        vectors++;
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL post_boot_seq got=%h want=%h", obs(), exp_v);
        end
    endtask

`ifdef PC_SEQ_DELAY_SLOT_EN
    task automatic test_delay_slot();
        goto(32'h0000_0300);
        jump        = 1'b1;
        jump_target = 32'h0000_0800;
        step();
        jump = 1'b0;
        exp_v = {32'h0000_0304, 2'd0, 1'b1, 1'b0, 1'b1};
        vectors++;
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL slot_seq got=%h want=%h", obs(), exp_v);
        end
        step();
        exp_v = {32'h0000_0800, 2'd2, 1'b1, 1'b0, 1'b0};
        vectors++;
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL slot_target got=%h want=%h", obs(), exp_v);
        end
        jump        = 1'b1;
        jump_target = 32'h0000_0900;
        step();
        jump          = 1'b0;
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0A00;
        step();
        exp_v = {32'h0000_0804, 2'd3, 1'b0, 1'b0, 1'b1};
        vectors++;
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL slot_stall got=%h want=%h", obs(), exp_v);
        end
        stall        = 1'b0;
        branch_taken = 1'b0;
        step();
        exp_v = {32'h0000_0900, 2'd2, 1'b1, 1'b0, 1'b0};
        vectors++;
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL slot_after_stall got=%h want=%h", obs(), exp_v);
        end
    endtask

    task automatic test_reset_mid_delay();
        jump        = 1'b1;
        jump_target = 32'h0000_0700;
        step();
        jump  = 1'b0;
        rst_n = 1'b0;
        step();
        exp_v = {RST_PC, 2'd3, 1'b0, 1'b1, 1'b1};
        vectors++;
        if (obs() !== exp_v) begin
            miscompares++;
            $display("FAIL rst_mid_delay got=%h want=%h", obs(), exp_v);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (pc !== RST_PC + 32'(i > 1 ? (i - 1) * 4 : 0)) begin
                miscompares++;
                $display("FAIL no_stale_target%0d got=%h want=%h", i, pc,
                         RST_PC + 32'(i > 1 ? (i - 1) * 4 : 0));
            end
        end
    endtask
`endif

    initial begin
        rst_n         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        stall         = 1'b0;
        #2;
        test_reset();
        test_wrap();
        test_stall();
        test_priority();
        test_jump_during_stall();
        test_reset_mid_stall();
`ifdef PC_SEQ_DELAY_SLOT_EN
        test_delay_slot();
        test_reset_mid_delay();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded by reset.
REQ-002 Parameter BOOT_CYCLES, default 2, is the number of cycles fetch is held after reset release; legal range is 1..15.
REQ-003 clk  input  1  is the single clock; all state updates occur on the rising edge.
REQ-004 rst_n  input  1  is the reset: synchronous, active-low.
REQ-005 branch_taken  input  1  is a conditional-branch redirect request, resolved in EX.
REQ-006 branch_target  input  32  is the branch destination address.
REQ-007 jump  input  1  is an unconditional jump redirect request, decoded in ID.
REQ-008 jump_target  input  32  is the jump destination address.
REQ-009 stall  input  1  is the load-use hazard hold request.
REQ-010 pc  output  32  is the registered fetch address.
REQ-011 pc_src  output  2  is the next-PC source select: 0 sequential, 1 branch, 2 jump, 3 hold.
REQ-012 if_id_write  output  1  enables the IF/ID pipeline register.
REQ-013 if_id_flush  output  1  zeroes the IF/ID pipeline register for one cycle.
REQ-014 busy  output  1  is high while in BOOT or DELAY.

Function
REQ-015 The FSM SHALL have states BOOT, RUN and STALL, plus DELAY only when the macro in REQ-032 is defined.
REQ-016 BOOT SHALL count BOOT_CYCLES cycles with pc held, pc_src=3, if_id_write=0 and if_id_flush=1, then go to RUN.
REQ-017 In RUN and STALL, next-PC priority SHALL be, highest first: branch_taken, stall, jump, sequential.
REQ-018 Sequential next PC SHALL be pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-019 The low two bits of both redirect targets SHALL be forced to 0 before use.
REQ-020 A stall without branch_taken SHALL hold pc, drive pc_src=3 and if_id_write=0, and put the FSM in STALL.
REQ-021 The FSM SHALL leave STALL for RUN on the first cycle in which stall=0.
REQ-022 branch_taken SHALL override stall in the same cycle; a jump arriving during a stall is ignored until the stall releases.
REQ-023 pc_src SHALL be registered together with pc and describe the source selected for the current pc update.
REQ-024 if_id_write SHALL be 1 in RUN whenever no stall is active.
REQ-025 All outputs SHALL be registered; the latency from a request at edge N to the new pc is one cycle (valid after edge N+1).
REQ-026 Redirect requests in BOOT SHALL be ignored.

Reset
REQ-027 While rst_n=0 at a rising edge, the block SHALL load pc=RESET_PC, pc_src=3, if_id_write=0, if_id_flush=1 and busy=1.
REQ-028 Reset SHALL also enter BOOT with the boot counter cleared and the saved-target register cleared to 0.
REQ-029 Reset asserted mid-stall or mid-DELAY SHALL abandon that operation; no pending target survives reset.

Configuration
REQ-030 Without the macro in REQ-032, an accepted redirect SHALL load the target at the next edge and assert if_id_flush for exactly that one cycle.
REQ-031 Without the macro in REQ-032, no DELAY state SHALL exist.
REQ-032 With macro PC_SEQ_DELAY_SLOT_EN defined, an accepted redirect SHALL advance pc to pc+4, save the target and enter DELAY, with no flush.
REQ-033 With PC_SEQ_DELAY_SLOT_EN defined, DELAY SHALL load the saved target with pc_src equal to the original source and return to RUN.
REQ-034 With PC_SEQ_DELAY_SLOT_EN defined, stall during DELAY SHALL hold the state and the saved target; redirects during DELAY are ignored.

Verification
REQ-035 Scenario: rst_n low for 1 cycle, RESET_PC=32'h0040_0000 -> pc=32'h0040_0000 with busy=1 for 2 cycles, then pc increments by 4 each cycle.
REQ-036 Scenario: pc=32'hFFFF_FFFC in RUN -> next pc=32'h0000_0000 with pc_src=0.
REQ-037 Scenario: stall high 3 cycles at pc=32'h100 -> pc holds 32'h100 and if_id_write=0 for 3 cycles, then pc=32'h104.
REQ-038 Scenario: branch_taken=1, stall=1 and jump=1 in the same cycle, branch_target=32'h203 -> next pc=32'h200, pc_src=1, and if_id_flush=1 for 1 cycle (macro off).
REQ-039 Scenario: macro on, jump at pc=32'h300 with jump_target=32'h800 -> pc sequence 32'h304, then 32'h800 with pc_src=2, and if_id_flush never asserted.
REQ-040 Scenario: rst_n low during DELAY -> pc=RESET_PC, and the saved target is never loaded afterwards.
